array_heap: RTL and testbench

ARRAY_HEAP -- requirements
Module: array_heap

---
 rtl/array_heap.sv | 169 ++++++++++++++++
 tb/tb_array_heap.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/array_heap.sv
// Array heap: fixed-size arrays carved from one word store, ids recycled through a LIFO.
// Optional ARRAY_HEAP_BOUNDS_CHECK_EN turns out-of-range/unallocated accesses into errors.
module array_heap #(
  parameter int WIDTH    = 12,
  parameter int N_AREA   = 2,
  parameter int N_ARRAYS = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arr,
  input  logic [WIDTH-1:0] cmd_idx,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] allocs,
  output logic [WIDTH-1:0] in_use
);
  localparam int DEPTH = N_ARRAYS * N_AREA;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW    = (N_ARRAYS > 1) ? $clog2(N_ARRAYS) : 1;

  localparam logic [2:0] OP_ALLOC = 3'd0;
  localparam logic [2:0] OP_FREE  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_READ  = 3'd3;
  localparam logic [2:0] OP_SIZE  = 3'd4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, next_state;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] arr_q, idx_q, data_q;
  logic [WIDTH-1:0] heap [DEPTH];
  logic [WIDTH-1:0] size [N_ARRAYS];
  logic [WIDTH-1:0] lifo [N_ARRAYS];
  logic [N_ARRAYS-1:0] allocated;
  logic [WIDTH-1:0] top;

  logic [2*WIDTH-1:0] addr_wide;
  logic [AW-1:0]      addr;
  logic [SW-1:0]      slot, pop_slot, push_slot, alloc_slot;
  logic [WIDTH-1:0]   alloc_id, idx_next;
  logic               alloc_ok, bad, exec_go;

  // Element address wraps over the whole store; array ids wrap over the id space.
  assign addr_wide  = {{WIDTH{1'b0}}, arr_q} * (2*WIDTH)'(N_AREA) + {{WIDTH{1'b0}}, idx_q};
  assign addr       = AW'(addr_wide % (2*WIDTH)'(DEPTH));
  assign slot       = SW'(arr_q % WIDTH'(N_ARRAYS));
  assign pop_slot   = SW'(top - WIDTH'(1));
  assign push_slot  = SW'(top);
  assign alloc_slot = SW'(alloc_id % WIDTH'(N_ARRAYS));
  assign idx_next   = idx_q + WIDTH'(1);
  assign exec_go    = (state == EXEC) && !reset;

  assign cmd_ready = (state == IDLE) && !reset;
  assign rsp_valid = (state == RESP) && !reset;

  always_comb begin
    alloc_ok = 1'b0;
    alloc_id = '0;
    if (top != '0) begin
      alloc_ok = 1'b1;
      alloc_id = lifo[pop_slot];
    end else if (allocs < WIDTH'(N_ARRAYS)) begin
      alloc_ok = 1'b1;
      alloc_id = allocs;
    end
  end

`ifdef ARRAY_HEAP_BOUNDS_CHECK_EN
  logic arr_bad, idx_bad;
  always_comb begin
    arr_bad = (arr_q >= WIDTH'(N_ARRAYS)) || !allocated[slot];
    idx_bad = idx_q >= WIDTH'(N_AREA);
    bad     = 1'b0;
    case (op_q)
      OP_WRITE, OP_READ: bad = arr_bad || idx_bad;
      OP_SIZE, OP_FREE:  bad = arr_bad;
      default:           bad = 1'b0;
    endcase
  end
`else
  assign bad = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_valid) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      allocs    <= '0;
      in_use    <= '0;
      top       <= '0;
      allocated <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        op_q   <= cmd_op;
        arr_q  <= cmd_arr;
        idx_q  <= cmd_idx;
        data_q <= cmd_data;
      end
      if (state == EXEC) begin
        rsp_err  <= 1'b0;
        rsp_data <= '0;
        if (bad) begin
          rsp_err <= 1'b1;
        end else begin
          case (op_q)
            OP_ALLOC: begin
              if (alloc_ok) begin
                rsp_data              <= alloc_id;
                allocated[alloc_slot] <= 1'b1;
                in_use                <= in_use + WIDTH'(1);
                if (top != '0) top    <= top - WIDTH'(1);
                else           allocs <= allocs + WIDTH'(1);
              end else begin
                rsp_err <= 1'b1;
              end
            end
            OP_FREE: begin
              if (top < WIDTH'(N_ARRAYS)) begin
                lifo[push_slot] <= arr_q;
                top             <= top + WIDTH'(1);
              end
              allocated[slot] <= 1'b0;
              in_use          <= in_use - WIDTH'(1);
              rsp_data        <= arr_q;
            end
            OP_WRITE: rsp_data <= data_q;
            OP_READ:  rsp_data <= heap[addr];
            OP_SIZE:  rsp_data <= size[slot];
            default:  rsp_err  <= 1'b1;
          endcase
        end
      end
    end
  end

  // Storage is deliberately outside reset so data survives reset and id reuse.
  always_ff @(posedge clock) begin
    if (exec_go && !bad) begin
      if (op_q == OP_WRITE) begin
        heap[addr] <= data_q;
        if (idx_next > size[slot]) size[slot] <= idx_next;
      end
      if (op_q == OP_ALLOC && alloc_ok) size[alloc_slot] <= '0;
    end
  end
endmodule

// File: tb/tb_array_heap.sv
// Directed bench for array_heap: stimulus pushes expected responses, a monitor pops and compares.
module tb_array_heap;
  localparam int W = 12;

  logic         clock = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_arr, cmd_idx, cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic [W-1:0] allocs, in_use;

  typedef struct packed {
    logic         err;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  array_heap #(.WIDTH(W), .N_AREA(2), .N_ARRAYS(2)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_arr(cmd_arr), .cmd_idx(cmd_idx), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .allocs(allocs), .in_use(in_use)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp data=%0d err=%0b", rsp_data, rsp_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rsp_data !== e.data || rsp_err !== e.err)
          begin
            errors++;
            $display("FAIL rsp got data=%0d err=%0b want data=%0d err=%0b",
                     rsp_data, rsp_err, e.data, e.err);
          end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] i,
                      input logic [W-1:0] d);
    int n;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = op; cmd_arr = a; cmd_idx = i; cmd_data = d;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clock); n++; end
    if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clock); n++; end
    if (exp_q.size() != 0) begin
      chk("rsp_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] i,
                       input logic [W-1:0] d, input logic [W-1:0] ed, input logic ee);
    exp_q.push_back('{err: ee, data: ed});
    send(op, a, i, d);
    drain();
  endtask

  task automatic wait_rsp_valid();
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clock); n++; end
    if (!rsp_valid) chk("rsp_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_arr = '0; cmd_idx = '0; cmd_data = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_allocs", allocs, 0);
    chk("rst_in_use", in_use, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("cmd_ready_after_rst", cmd_ready, 1);

    // basic alloc / write / read
    issue(3'd0, 0, 0, 0, 0, 0);
    issue(3'd2, 0, 0, 11, 11, 0);
    issue(3'd2, 0, 1, 22, 22, 0);
    issue(3'd0, 0, 0, 0, 1, 0);
    issue(3'd2, 1, 1, 33, 33, 0);
    issue(3'd3, 0, 0, 0, 11, 0);
    issue(3'd3, 0, 1, 0, 22, 0);
    issue(3'd3, 1, 1, 0, 33, 0);
    chk("allocs_2", allocs, 2);
    chk("in_use_2", in_use, 2);

    // sizes and exhaustion
    issue(3'd4, 0, 0, 0, 2, 0);
    issue(3'd4, 1, 0, 0, 2, 0);
    issue(3'd0, 0, 0, 0, 0, 1);
    chk("allocs_full", allocs, 2);
    chk("in_use_full", in_use, 2);

    // LIFO reuse
    issue(3'd1, 0, 0, 0, 0, 0);
    issue(3'd1, 1, 0, 0, 1, 0);
    chk("in_use_0", in_use, 0);
    issue(3'd0, 0, 0, 0, 1, 0);
    issue(3'd0, 0, 0, 0, 0, 0);
    issue(3'd4, 1, 0, 0, 0, 0);
    issue(3'd4, 0, 0, 0, 0, 0);
    issue(3'd3, 1, 1, 0, 33, 0);
    chk("in_use_reuse", in_use, 2);
    chk("allocs_reuse", allocs, 2);

    // illegal opcode
    issue(3'd5, 0, 0, 0, 0, 1);
    issue(3'd7, 1, 1, 9, 0, 1);
    chk("in_use_illegal", in_use, 2);

    // response backpressure
    rsp_ready = 1'b0;
    exp_q.push_back('{err: 1'b0, data: W'(11)});
    send(3'd3, 0, 0, 0);
    wait_rsp_valid();
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_data", rsp_data, 11);
      chk("stall_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    drain();

`ifdef ARRAY_HEAP_BOUNDS_CHECK_EN
    issue(3'd3, 0, 2, 0, 0, 1);
    issue(3'd1, 1, 0, 0, 1, 0);
    chk("in_use_free1", in_use, 1);
    issue(3'd1, 1, 0, 0, 0, 1);
    chk("in_use_bad_free", in_use, 1);
    issue(3'd0, 0, 0, 0, 1, 0);
    chk("in_use_realloc", in_use, 2);
`else
    issue(3'd2, 0, 2, 44, 44, 0);
    issue(3'd3, 1, 0, 0, 44, 0);
`endif

    // reset while a response is pending
    rsp_ready = 1'b0;
    exp_q.push_back('{err: 1'b0, data: W'(11)});
    send(3'd3, 0, 0, 0);
    wait_rsp_valid();
    reset = 1'b1;
    @(negedge clock);
    exp_q.delete();
    chk("rst_resp_rsp_valid", rsp_valid, 0);
    chk("rst_resp_allocs", allocs, 0);
    chk("rst_resp_in_use", in_use, 0);
    reset = 1'b0;
    rsp_ready = 1'b1;
    issue(3'd0, 0, 0, 0, 0, 0);
    issue(3'd3, 0, 0, 0, 11, 0);
    chk("allocs_after_rst", allocs, 1);

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
